// File: rtl/frame_lock_pkg.sv
// Shared types, limits and helpers for the frame-buffer lock manager.
// Statistics counters are built only when FRAME_LOCK_STATS_EN is defined.
package frame_lock_pkg;

    localparam int MAX_BUF = 16;
    localparam int MAX_RD  = 4;
    localparam int SAT_W   = 32;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        WRITING = 2'd1,
        NEWEST  = 2'd2,
        HELD    = 2'd3
    } buf_state_e;

    // NEWEST outranks HELD when a buffer is both, matching what a reader would fetch next.
    function automatic buf_state_e buf_state(input logic writing, input logic newest,
                                             input logic held);
        if (writing)
            return WRITING;
        else if (newest)
            return NEWEST;
        else if (held)
            return HELD;
        return FREE;
    endfunction

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int w);
        logic [SAT_W-1:0] w_lim;
        w_lim = {SAT_W{1'b1}} >> (SAT_W - w);
        return (v == w_lim) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/frame_lock_alloc.sv
// Lowest-index-set priority encoder used to pick the writer's next buffer.
// Part of frame_buf_lock (optional stats via FRAME_LOCK_STATS_EN, not used here).
module frame_lock_alloc
    import frame_lock_pkg::*;
#(
    parameter int NUM_BUF = 3,
    parameter int IDX_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1
) (
    input  logic [NUM_BUF-1:0] i_free,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int b = NUM_BUF - 1; b >= 0; b--) begin
            if (i_free[b]) begin
                o_idx   = IDX_W'(b);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_buf_lock.sv
// Frame-buffer lock manager: one writer, NUM_RD readers, newest-frame publication.
// Define FRAME_LOCK_STATS_EN to build the drop/skip statistics counters.
module frame_buf_lock
    import frame_lock_pkg::*;
#(
    parameter int NUM_BUF = 3,
    parameter int NUM_RD  = 1,
    parameter int IDX_W   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1,
    parameter int CNT_W   = 16
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    wr_frame_start,
    input  logic                    wr_frame_done,
    output logic [IDX_W-1:0]        wr_buf,
    output logic                    wr_valid,
    input  logic [NUM_RD-1:0]       rd_frame_start,
    input  logic [NUM_RD-1:0]       rd_freeze,
    output logic [NUM_RD*IDX_W-1:0] rd_buf,
    output logic [NUM_RD-1:0]       rd_valid,
    output logic [IDX_W-1:0]        newest_buf,
    output logic                    newest_valid,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic [CNT_W-1:0]        skip_cnt
);

    if (NUM_RD < 1 || NUM_RD > MAX_RD || NUM_BUF < NUM_RD + 2 || NUM_BUF > MAX_BUF) begin : g_bad_cfg
        $error("frame_buf_lock: NUM_BUF/NUM_RD outside supported range");
    end

    logic [IDX_W-1:0]   r_wr_buf;
    logic               r_wr_valid;
    logic [IDX_W-1:0]   r_newest_buf;
    logic               r_newest_valid;
    logic [IDX_W-1:0]   r_rd_buf [NUM_RD];
    logic [NUM_RD-1:0]  r_rd_valid;

    logic               w_publish;
    logic               w_wr_valid_mid;
    logic [IDX_W-1:0]   w_newest_buf_nxt;
    logic               w_newest_valid_nxt;
    logic [NUM_RD-1:0]  w_rd_take;
    logic [IDX_W-1:0]   w_rd_buf_nxt [NUM_RD];
    logic [NUM_RD-1:0]  w_rd_valid_nxt;
    logic [NUM_BUF-1:0] w_held;
    logic [NUM_BUF-1:0] w_free;
    logic [IDX_W-1:0]   w_alloc_idx;
    logic               w_alloc_found;
    logic [IDX_W-1:0]   w_wr_buf_nxt;
    logic               w_wr_valid_nxt;

    // Done is applied first, so readers starting in the same cycle see the fresh frame.
    always_comb begin
        w_publish          = wr_frame_done && r_wr_valid;
        w_wr_valid_mid     = r_wr_valid && !wr_frame_done;
        w_newest_buf_nxt   = w_publish ? r_wr_buf : r_newest_buf;
        w_newest_valid_nxt = w_publish || r_newest_valid;
        w_held             = '0;
        w_free             = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            w_rd_take[r]      = rd_frame_start[r] && !rd_freeze[r] && w_newest_valid_nxt;
            w_rd_buf_nxt[r]   = w_rd_take[r] ? w_newest_buf_nxt : r_rd_buf[r];
            w_rd_valid_nxt[r] = w_rd_take[r] || r_rd_valid[r];
        end
        // The writing buffer is left out on purpose: a start either aborts it or finds none.
        for (int b = 0; b < NUM_BUF; b++) begin
            for (int r = 0; r < NUM_RD; r++) begin
                if (w_rd_valid_nxt[r] && w_rd_buf_nxt[r] == IDX_W'(b))
                    w_held[b] = 1'b1;
            end
            w_free[b] = !w_held[b] && !(w_newest_valid_nxt && w_newest_buf_nxt == IDX_W'(b));
        end
    end

    frame_lock_alloc #(
        .NUM_BUF (NUM_BUF),
        .IDX_W   (IDX_W)
    ) u_alloc (
        .i_free  (w_free),
        .o_idx   (w_alloc_idx),
        .o_found (w_alloc_found)
    );

    always_comb begin
        w_wr_buf_nxt   = r_wr_buf;
        w_wr_valid_nxt = w_wr_valid_mid;
        if (wr_frame_start) begin
            w_wr_valid_nxt = w_alloc_found;
            if (w_alloc_found)
                w_wr_buf_nxt = w_alloc_idx;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_buf       <= '0;
            r_wr_valid     <= 1'b0;
            r_newest_buf   <= '0;
            r_newest_valid <= 1'b0;
            r_rd_valid     <= '0;
            for (int r = 0; r < NUM_RD; r++)
                r_rd_buf[r] <= '0;
        end else begin
            r_wr_buf       <= w_wr_buf_nxt;
            r_wr_valid     <= w_wr_valid_nxt;
            r_newest_buf   <= w_newest_buf_nxt;
            r_newest_valid <= w_newest_valid_nxt;
            r_rd_valid     <= w_rd_valid_nxt;
            for (int r = 0; r < NUM_RD; r++)
                r_rd_buf[r] <= w_rd_buf_nxt[r];
        end
    end

    assign wr_buf       = r_wr_buf;
    assign wr_valid     = r_wr_valid;
    assign newest_buf   = r_newest_buf;
    assign newest_valid = r_newest_valid;
    assign rd_valid     = r_rd_valid;
    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd_out
        assign rd_buf[r*IDX_W +: IDX_W] = r_rd_buf[r];
    end

`ifdef FRAME_LOCK_STATS_EN
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_skip_cnt;
    logic             r_newest_taken;

    // A skip is a published frame replaced before any reader fetched it.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_drop_cnt     <= '0;
            r_skip_cnt     <= '0;
            r_newest_taken <= 1'b0;
        end else begin
            if (w_publish && r_newest_valid && !r_newest_taken)
                r_skip_cnt <= CNT_W'(sat_inc(SAT_W'(r_skip_cnt), CNT_W));
            if (wr_frame_start && w_wr_valid_mid)
                r_drop_cnt <= CNT_W'(sat_inc(SAT_W'(r_drop_cnt), CNT_W));
            r_newest_taken <= (|w_rd_take) || (r_newest_taken && !w_publish);
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign skip_cnt = r_skip_cnt;
`else
    assign drop_cnt = '0;
    assign skip_cnt = '0;
`endif

endmodule
